// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//   Shared types and helpers for the debounce_bank input conditioner.
//   - ch_state_t : per-channel debounce FSM states
//   - cnt_width  : width of the shared debounce/hold counter
// ---------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [2:0] {
    LOW,
    PEND_HI,
    HIGH,
    HELD,
    PEND_LO
  } ch_state_t;

  // Bits needed to hold max(debounce_time, hold_time), i.e.
  // clog2(max(debounce_time, hold_time) + 1). Never returns less than 1.
  function automatic int cnt_width(input int debounce_time, input int hold_time);
    int max_val;
    int width;
    max_val = (debounce_time > hold_time) ? debounce_time : hold_time;
    width   = 1;
    for (int i = 0; i < 31; i++) begin
      if ((max_val >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// ---------------------------------------------------------------------------
// debounce_ch
//   One channel of the input conditioner: synchroniser, debounce FSM and the
//   shared debounce/hold counter.
//
//   Ports
//     clk    in   system clock
//     nReset in   asynchronous active-low reset
//     raw    in   asynchronous button/switch input
//     level  out  debounced level
//     rise   out  one-cycle pulse when level goes 0->1
//     fall   out  one-cycle pulse when level goes 1->0
//     held   out  one-cycle pulse when level has been high HOLD_TIME cycles
// ---------------------------------------------------------------------------
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   DEBOUNCE_TIME = 1000000,
  parameter int   HOLD_TIME     = 50000000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic nReset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic held
);

  localparam int CNT_W = cnt_width(DEBOUNCE_TIME, HOLD_TIME);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TIME - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_TIME == 0) ? '0 : CNT_W'(HOLD_TIME - 1);

  // -------------------------------------------------------------------------
  // Synchroniser
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_reg <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Debounce FSM
  // -------------------------------------------------------------------------
  ch_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             was_held_reg, was_held_next;
  logic             level_reg, level_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;
  logic             held_reg, held_next;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg    <= RESET_LEVEL ? HIGH : LOW;
      cnt_reg      <= '0;
      was_held_reg <= 1'b0;
      level_reg    <= RESET_LEVEL;
      rise_reg     <= 1'b0;
      fall_reg     <= 1'b0;
      held_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      was_held_reg <= was_held_next;
      level_reg    <= level_next;
      rise_reg     <= rise_next;
      fall_reg     <= fall_next;
      held_reg     <= held_next;
    end
  end

  // The counter holds the number of consecutive mismatching samples already
  // seen while pending, so the sample that leaves LOW/HIGH/HELD counts as the
  // first one. That keeps acceptance at exactly DEBOUNCE_TIME samples, and
  // with DEBOUNCE_TIME=1 the pending states are skipped altogether.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    was_held_next = was_held_reg;
    rise_next     = 1'b0;
    fall_next     = 1'b0;
    held_next     = 1'b0;

    case (state_reg)
      LOW: begin
        cnt_next = '0;
        if (s) begin
          if (DEBOUNCE_TIME == 1) begin
            state_next = HIGH;
            rise_next  = 1'b1;
          end else begin
            state_next = PEND_HI;
            cnt_next   = CNT_ONE;
          end
        end
      end

      PEND_HI: begin
        if (!s) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt_reg == DB_LAST) begin
          state_next = HIGH;
          rise_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      HIGH: begin
        if (!s) begin
          was_held_next = 1'b0;
          if (DEBOUNCE_TIME == 1) begin
            state_next = LOW;
            fall_next  = 1'b1;
            cnt_next   = '0;
          end else begin
            state_next = PEND_LO;
            cnt_next   = CNT_ONE;
          end
        end else if (HOLD_TIME != 0 && cnt_reg == HOLD_LAST) begin
          state_next = HELD;
          held_next  = 1'b1;
          cnt_next   = '0;
        end else if (HOLD_TIME != 0) begin
          // Stops at HOLD_LAST, so the counter never wraps.
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      HELD: begin
        cnt_next = '0;
        if (!s) begin
          was_held_next = 1'b1;
          if (DEBOUNCE_TIME == 1) begin
            state_next = LOW;
            fall_next  = 1'b1;
          end else begin
            state_next = PEND_LO;
            cnt_next   = CNT_ONE;
          end
        end
      end

      PEND_LO: begin
        if (s) begin
          // Glitch on release: go back where we came from. Returning to HELD
          // keeps held from re-firing within the same press.
          state_next = was_held_reg ? HELD : HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == DB_LAST) begin
          state_next = LOW;
          fall_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase

    level_next = (state_next == HIGH) || (state_next == HELD) || (state_next == PEND_LO);
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;
  assign held  = held_reg;

endmodule

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//   N_CH independent debounce channels for push-buttons and switches.
//
//   Ports
//     clk    in   system clock
//     nReset in   asynchronous active-low reset
//     raw    in   [N_CH] asynchronous raw inputs
//     level  out  [N_CH] debounced levels
//     rise   out  [N_CH] one-cycle 0->1 pulses
//     fall   out  [N_CH] one-cycle 1->0 pulses
//     held   out  [N_CH] one-cycle long-press pulses
// ---------------------------------------------------------------------------
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   N_CH          = 4,
  parameter int   SYNC_STAGES   = 2,
  parameter int   DEBOUNCE_TIME = 1000000,
  parameter int   HOLD_TIME     = 50000000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_TIME(DEBOUNCE_TIME),
      .HOLD_TIME    (HOLD_TIME),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_ch (
      .clk   (clk),
      .nReset(nReset),
      .raw   (raw[gi]),
      .level (level[gi]),
      .rise  (rise[gi]),
      .fall  (fall[gi]),
      .held  (held[gi])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
//   Two instances (RESET_LEVEL 0 and 1) driven by directed phases followed by
//   random stimulus. A reference model built from run lengths of the sampled
//   input predicts every output every cycle.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

  localparam int N_CH          = 2;
  localparam int SYNC_STAGES   = 2;
  localparam int DEBOUNCE_TIME = 4;
  localparam int HOLD_TIME     = 10;
  localparam int N_M           = 2 * N_CH;   // model channels: a[0..], then b[0..]

  logic            clk = 1'b0;
  logic            nReset;
  logic [N_CH-1:0] raw_a, raw_b;
  logic [N_CH-1:0] level_a, rise_a, fall_a, held_a;
  logic [N_CH-1:0] level_b, rise_b, fall_b, held_b;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_TIME(DEBOUNCE_TIME),
    .HOLD_TIME(HOLD_TIME), .RESET_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .nReset(nReset), .raw(raw_a),
    .level(level_a), .rise(rise_a), .fall(fall_a), .held(held_a)
  );

  debounce_bank #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_TIME(DEBOUNCE_TIME),
    .HOLD_TIME(HOLD_TIME), .RESET_LEVEL(1'b1)
  ) dut_b (
    .clk(clk), .nReset(nReset), .raw(raw_b),
    .level(level_b), .rise(rise_b), .fall(fall_b), .held(held_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: a new level is accepted after DEBOUNCE_TIME consecutive
  // samples that differ from it; held fires once per press after HOLD_TIME
  // consecutive matching high samples, counted afresh after any glitch.
  // -------------------------------------------------------------------------
  bit             m_pipe [N_M][SYNC_STAGES];
  bit             m_lvl  [N_M];
  int             m_mis  [N_M];
  int             m_hrun [N_M];
  bit             m_hdone[N_M];
  logic [N_M-1:0] exp_level, exp_rise, exp_fall, exp_held;

  task automatic m_reset();
    for (int c = 0; c < N_M; c++) begin
      bit rl;
      rl = (c >= N_CH);
      for (int k = 0; k < SYNC_STAGES; k++) m_pipe[c][k] = rl;
      m_lvl[c]   = rl;
      m_mis[c]   = 0;
      m_hrun[c]  = 0;
      m_hdone[c] = 1'b0;
    end
    exp_rise = '0;
    exp_fall = '0;
    exp_held = '0;
    for (int c = 0; c < N_M; c++) exp_level[c] = m_lvl[c];
  endtask

  task automatic m_step();
    logic [N_M-1:0] r;
    r = {raw_b, raw_a};
    exp_rise = '0;
    exp_fall = '0;
    exp_held = '0;
    for (int c = 0; c < N_M; c++) begin
      bit s;
      s = m_pipe[c][SYNC_STAGES-1];
      for (int k = SYNC_STAGES - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
      m_pipe[c][0] = r[c];
      if (s != m_lvl[c]) begin
        m_mis[c]++;
        if (m_mis[c] == DEBOUNCE_TIME) begin
          m_lvl[c]   = s;
          m_mis[c]   = 0;
          m_hrun[c]  = 0;
          m_hdone[c] = 1'b0;
          if (s) exp_rise[c] = 1'b1;
          else   exp_fall[c] = 1'b1;
        end
      end else if (m_mis[c] != 0) begin
        m_mis[c]  = 0;
        m_hrun[c] = 0;
      end else if (m_lvl[c] && !m_hdone[c] && HOLD_TIME != 0) begin
        m_hrun[c]++;
        if (m_hrun[c] == HOLD_TIME) begin
          exp_held[c] = 1'b1;
          m_hdone[c]  = 1'b1;
        end
      end
      exp_level[c] = m_lvl[c];
    end
  endtask

  task automatic compare_all();
    check_val("level", 32'({level_b, level_a}), 32'(exp_level));
    check_val("rise",  32'({rise_b,  rise_a}),  32'(exp_rise));
    check_val("fall",  32'({fall_b,  fall_a}),  32'(exp_fall));
    check_val("held",  32'({held_b,  held_a}),  32'(exp_held));
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic tick();
    @(posedge clk);
    if (nReset) m_step();
    else        m_reset();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic assert_reset();
    nReset = 1'b0;
    m_reset();
    #1;
    compare_all();
  endtask

  int lat, cnt_a, cnt_b, cnt_c, first_b, tmp;
  logic [N_CH-1:0] seen;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    nReset = 1'b0;
    raw_a  = 2'b00;
    raw_b  = 2'b11;
    m_reset();
    @(negedge clk);
    compare_all();
    repeat (3) tick();

    // Phase A: idle after reset; RESET_LEVEL=1 instance holds through release
    nReset = 1'b1;
    cnt_a = 0; cnt_b = 0; first_b = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((rise_a | fall_a | held_a) != 0) cnt_a++;
      if (rise_b != 0) cnt_b++;
      if (i == 1) check_val("rl1_level_after_release", 32'(level_b), 32'(2'b11));
      if (held_b == 2'b11 && first_b < 0) first_b = i;
    end
    check_val("idle_pulses_a", cnt_a, 0);
    check_val("rl1_no_rise", cnt_b, 0);
    check_val("rl1_held_delay", first_b, HOLD_TIME);
    $display("phase idle: rl1 held after %0d cycles", first_b);

    // Phase A2: clean press on channel 0
    raw_a = 2'b01;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (rise_a[0]) begin
        lat = i;
        check_val("level_with_rise", 32'(level_a[0]), 1);
      end
    end
    check_val("rise_latency", lat, SYNC_STAGES + DEBOUNCE_TIME);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (held_a[0]) lat = i;
    end
    check_val("held_after_rise", lat, HOLD_TIME);
    $display("phase press: held %0d cycles after rise", lat);

    // Phase B: bounce then settle high
    raw_a = 2'b00;
    repeat (12) tick();
    cnt_a = 0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      raw_a[0] = (i <= 8) ? (((i - 1) / 2) % 2 == 0) : 1'b1;
      tick();
      if (rise_a[0]) begin
        cnt_a++;
        if (lat < 0) lat = i;
      end
    end
    check_val("bounce_rise_count", cnt_a, 1);
    check_val("bounce_rise_delay", lat - 9 + 1, SYNC_STAGES + DEBOUNCE_TIME);
    $display("phase bounce: %0d rise pulses", cnt_a);

    // Phase C: release glitch while held
    cnt_a = 0;
    for (int i = 1; i <= 15 && cnt_a == 0; i++) begin
      tick();
      if (held_a[0]) cnt_a++;
    end
    check_val("held_before_glitch", cnt_a, 1);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 1; i <= 22; i++) begin
      raw_a[0] = (i > 2);
      tick();
      if (fall_a[0]) cnt_a++;
      if (held_a[0]) cnt_b++;
      if (!level_a[0]) cnt_c++;
    end
    check_val("glitch_no_fall", cnt_a, 0);
    check_val("glitch_no_reheld", cnt_b, 0);
    check_val("glitch_level_low_cycles", cnt_c, 0);
    raw_a = 2'b00;
    cnt_a = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (fall_a[0]) cnt_a++;
    end
    check_val("release_fall_count", cnt_a, 1);
    $display("phase glitch: %0d fall pulses on release", cnt_a);

    // Phase D: simultaneous press, then release only channel 1
    raw_a = 2'b11;
    seen = '0;
    for (int i = 1; i <= 12 && seen == 0; i++) begin
      tick();
      seen = rise_a;
    end
    check_val("simul_rise", 32'(seen), 32'(2'b11));
    raw_a = 2'b01;
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (fall_a[1]) cnt_a++;
      if (fall_a[0]) cnt_b++;
    end
    check_val("fall_ch1_count", cnt_a, 1);
    check_val("fall_ch0_count", cnt_b, 0);
    $display("phase simultaneous: rise=%b", seen);

    // Phase E: reset in PEND_HI with the counter at 3
    raw_a = 2'b00;
    repeat (12) tick();
    raw_a = 2'b01;
    repeat (5) tick();
    assert_reset();
    check_val("rst_level_a", 32'(level_a), 0);
    check_val("rst_pulses_a", 32'({rise_a, fall_a, held_a}), 0);
    repeat (2) tick();
    nReset = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (rise_a[0]) lat = i;
    end
    check_val("rise_latency_after_reset", lat, SYNC_STAGES + DEBOUNCE_TIME);
    $display("phase reset: rise %0d cycles after release", lat);

    // Phase F: random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        tmp = $urandom_range(0, N_M - 1);
        if (tmp < N_CH) raw_a[tmp] = ~raw_a[tmp];
        else            raw_b[tmp - N_CH] = ~raw_b[tmp - N_CH];
      end
      if ($urandom_range(0, 999) == 0) begin
        assert_reset();
        tick();
        nReset = 1'b1;
      end
      tick();
    end
    $display("phase random: 3000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
